mant_align: RTL
===============

# mant_align

Iterative mantissa alignment shifter for the floating-point adder datapath. It right-shifts the smaller operand's 24-bit significand by the exponent difference and produces guard, round and sticky bits. It runs before the add, the opposite end of the datapath from post-add normalization. Each transaction uses a valid/ready handshake on both the input and output sides.

## Interface
- WIDTH, 24, significand width including hidden bit
- DW, 8, width of exponent-difference input
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept; high only in IDLE and not in reset
- in_mant  input  WIDTH  significand to align
- in_shift  input  DW  right-shift amount (unsigned exponent difference)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_mant  output  WIDTH  aligned significand
- out_grs  output  3  {guard, round, sticky}

## Operation
- Internal state: mant register (WIDTH), g, r, s bits, remaining count (DW).
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:** in_ready=1. On in_valid, the block captures in_mant into mant, sets g=r=s=0 and remaining=in_shift.
  - in_shift==0 → DONE.
  - in_shift ≥ WIDTH+3 (27) → clamp: mant=0, g=0, r=0, s=|in_mant → DONE.
  - Otherwise → SHIFT.
- **SHIFT, one-bit step per edge:** s|=r; r<=g; g<=mant[0]; mant<=mant>>1; remaining--. When remaining==1 the step is taken and next state is DONE.
- **Early termination:** in SHIFT, if {mant,g,r}==0, go to DONE with no change. Results are unchanged because further shifts cannot alter them.
- **DONE:** out_valid=1. out_mant=mant and out_grs={g,r,s} are held stable. On out_ready, go to IDLE. There is no same-cycle re-accept; in_ready rises the cycle after the output handshake.
- Bits shifted past r are ORed into s; s never clears within a transaction.

## Timing
- Reset values: state=IDLE, out_valid=0, out_mant=0, out_grs=000, in_ready=0 while rst is high.
- Let accept edge = E0. For in_shift=N (1≤N≤26), out_valid is first high after edge E0+N.
- N=0, the clamp case, and early termination at the first SHIFT edge give:
  - N=0 or clamp: out_valid after E0.
  - Zero operand: out_valid after E1.
- Backpressure: in DONE with out_ready low, all outputs are held indefinitely.
- Reset mid-operation (any state): next cycle state=IDLE and out_valid=0. The in-flight transaction is discarded.
- in_valid while not IDLE is ignored. The upstream must hold data until in_ready.

## Configuration
- ALIGN_FAST_SHIFT_EN:
  - Defined: each SHIFT edge shifts by 4 when remaining≥4, otherwise by 1. s also ORs the bits that drop off. Latency is N/4 + N%4 edges (integer division); N=25 takes 7 edges.
  - Undefined: one bit per edge.
- Results are bit-identical in both modes; only latency differs.

## Test plan
- Zero shift: in_mant=0xC00001, in_shift=0 → out_mant=0xC00001, out_grs=000, out_valid after E0.
- Two-bit shift: in_mant=0x800003, in_shift=2 → out_mant=0x200000, out_grs=110, out_valid after E2.
- Deep shift: in_mant=0x800001, in_shift=25 → out_mant=0x000000, out_grs=011, out_valid after E25 (after E7 with ALIGN_FAST_SHIFT_EN).
- Clamp: in_mant=0xFFFFFF, in_shift=30 → out_mant=0, out_grs=001, out_valid after E0. Repeat with in_mant=0 → out_grs=000.
- Early termination: in_mant=0x000000, in_shift=20 → out_mant=0, out_grs=000, out_valid after E1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Release → in_ready=1 the next cycle.
  - Assert rst at E3 of an in_shift=10 transaction → out_valid=0, state IDLE, in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/mant_align.sv
// Iterative significand alignment shifter producing guard/round/sticky bits.
// Define ALIGN_FAST_SHIFT_EN to shift four bits per cycle while at least four remain.
module mant_align #(
  parameter int WIDTH = 24,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [DW-1:0]    in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [2:0]       out_grs
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [DW-1:0] CLAMP_SHIFT = DW'(WIDTH + 3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mant_q, mant_d;
  logic             g_q, g_d;
  logic             r_q, r_d;
  logic             s_q, s_d;
  logic [DW-1:0]    rem_q, rem_d;
  logic             fast_step;

`ifdef ALIGN_FAST_SHIFT_EN
  assign fast_step = (rem_q >= DW'(4));
`else
  assign fast_step = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d = in_mant;
          g_d    = 1'b0;
          r_d    = 1'b0;
          s_d    = 1'b0;
          rem_d  = in_shift;
          if (in_shift == '0) begin
            state_d = DONE;
          end else if (in_shift >= CLAMP_SHIFT) begin
            // Everything falls past the round bit: only sticky survives.
            mant_d  = '0;
            s_d     = |in_mant;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Once mant, g and r are all zero, further shifting cannot change the result.
        if ({mant_q, g_q, r_q} == '0) begin
          state_d = DONE;
        end else begin
          if (fast_step) begin
            s_d    = s_q | r_q | g_q | mant_q[1] | mant_q[0];
            r_d    = mant_q[2];
            g_d    = mant_q[3];
            mant_d = mant_q >> 4;
            rem_d  = rem_q - DW'(4);
          end else begin
            s_d    = s_q | r_q;
            r_d    = g_q;
            g_d    = mant_q[0];
            mant_d = mant_q >> 1;
            rem_d  = rem_q - DW'(1);
          end
          if (rem_d == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_mant  = mant_q;
  assign out_grs   = {g_q, r_q, s_q};

endmodule
